// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One radix-2 step per cycle: shift-add multiply, restoring divide, then a
// sign-fix cycle and a one-cycle done pulse. Divide-by-zero and signed
// overflow finish directly without iterating.
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   start, Funct3      M-extension op valid and op select
//   SrcA, SrcB         rs1 / rs2 operands
//   flush              abort the op in flight, block acceptance in IDLE
//   busy               op in CALC, FIX or DONE (registered)
//   stall              freeze IF/ID/EX (combinational)
//   done, Result       one-cycle result valid, result held until next done
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [2:0]      op;
    logic            neg;    // negate the selected result in FIX
    logic [XLEN-1:0] opnd;   // |A| for multiply, |B| (divisor) for divide
    logic [PW-1:0]   acc;    // product, or {remainder, quotient}
    logic [CW-1:0]   cnt;

    // Operand decode at issue: signedness, magnitudes, special divide results
    logic            signed_a, signed_b, in_sign_a, in_sign_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, special;

    always_comb begin
        if (Funct3[2]) begin
            signed_a = ~Funct3[0];
            signed_b = ~Funct3[0];
        end else begin
            signed_a = (Funct3[1:0] != 2'b11);
            signed_b = ~Funct3[1];
        end
        in_sign_a = signed_a & SrcA[XLEN-1];
        in_sign_b = signed_b & SrcB[XLEN-1];
        abs_a     = in_sign_a ? (~SrcA + XLEN'(1)) : SrcA;
        abs_b     = in_sign_b ? (~SrcB + XLEN'(1)) : SrcB;
        div_zero  = (SrcB == '0);
        div_ovf   = ~Funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
        if (div_zero) begin
            special = Funct3[1] ? SrcA : '1;
        end else begin
            // overflow: quotient is the dividend itself, remainder zero
            special = Funct3[1] ? '0 : SrcA;
        end
    end

    // One iteration step and the final sign fix / output select
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [PW-1:0]   step_next, prod_fix;
    logic [XLEN-1:0] div_sel, fix_val;

    always_comb begin
        mul_sum   = {1'b0, acc[PW-1:XLEN]} + {1'b0, opnd};
        div_shift = {acc[PW-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op[2]) begin
            // restore on borrow, otherwise keep the difference and shift in a 1
            if (div_diff[XLEN]) begin
                step_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                step_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            step_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[PW-1:1]};
        end

        prod_fix = neg ? (~acc + PW'(1)) : acc;
        div_sel  = op[1] ? acc[PW-1:XLEN] : acc[XLEN-1:0];
        if (op[2]) begin
            fix_val = neg ? (~div_sel + XLEN'(1)) : div_sel;
        end else if (op[1:0] == 2'b00) begin
            fix_val = prod_fix[XLEN-1:0];
        end else begin
            fix_val = prod_fix[PW-1:XLEN];
        end
    end

    // Only a fresh, unflushed start can stall from IDLE
    assign stall = (state == IDLE) ? (start & ~flush) : ((state == CALC) || (state == FIX));

    // Control FSM with registered busy/done/Result
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            op     <= '0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op   <= Funct3;
                        neg  <= (Funct3[2] && Funct3[1]) ? in_sign_a : (in_sign_a ^ in_sign_b);
                        opnd <= Funct3[2] ? abs_b : abs_a;
                        acc  <= Funct3[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (Funct3[2] && (div_zero || div_ovf)) begin
                            Result <= special;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(XLEN - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        Result <= fix_val;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are queued at issue
// and compared whenever done pulses; latency and stall are checked per op.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        busy, stall, done;
    logic [31:0] Result;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];
    logic [31:0] last_exp = 32'h0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model built on 64-bit host arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb_v, ua, ub, q;
        logic [63:0] p;
        logic        ovf;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        ua   = longint'(a);
        ub   = longint'(b);
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = 64'h0;
        case (f)
            3'd0: begin p = ua * ub;   return p[31:0];  end
            3'd1: begin p = sa * sb_v; return p[63:32]; end
            3'd2: begin p = sa * ub;   return p[63:32]; end
            3'd3: begin p = ua * ub;   return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = sa / sb_v; p = q; return p[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                q = sa % sb_v; p = q; return p[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    // Scoreboard side: every done pulse must match the oldest queued result
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) check("unexpected_done", {31'b0, done}, 32'd0);
            else                check("result", Result, sb.pop_front());
        end
    end

    // Issue one op in the next IDLE cycle and follow it to done.
    // poke != 0 pulses start again at that cycle of the op.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int poke);
        int n = 0;
        int stall_bad = 0;
        logic got = 1'b0;
        @(negedge clk);
        start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
        sb.push_back(exp);
        last_exp = exp;
        #1;
        check("stall_issue", 32'(stall), 32'd1);
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else if (!stall) stall_bad++;
            start = (poke != 0 && n == poke);
            if (start) begin Funct3 = 3'b100; SrcA = 32'h55; SrcB = 32'h0; end
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(lat));
        check("stall_during_op", 32'(stall_bad), 32'd0);
        check("stall_done", 32'(stall), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        Funct3 = 3'b0; SrcA = 32'h0; SrcB = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", Result, 32'h0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b1;

        // Directed vectors; consecutive calls issue back-to-back after DONE
        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        run_op(3'd5, 32'd100,       32'd7,         32'd14,        34, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
        run_op(3'd7, 32'd100,       32'd7,         32'd2,         34, 0);
        run_op(3'd5, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 1,  0);
        run_op(3'd7, 32'h1234_5678, 32'h0,         32'h1234_5678, 1,  0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  0);

        // start pulsed mid-CALC must not launch a second op
        run_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, 34, 5);
        repeat (40) @(negedge clk);

        // flush at CALC cycle 10: abort, no done, Result kept
        @(negedge clk);
        start = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_result_kept", Result, last_exp);

        // flush in IDLE blocks acceptance and stall
        start = 1'b1; flush = 1'b1; Funct3 = 3'd5; SrcA = 32'd9; SrcB = 32'd3;
        #1;
        check("idle_flush_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);

        // reset mid-CALC clears everything
        start = 1'b1; Funct3 = 3'd5; SrcA = 32'd1000; SrcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", Result, 32'h0);
        check("midrst_stall", 32'(stall), 32'd0);
        reset = 1'b1;
        last_exp = 32'h0;

        // Random ops against the model, some with a zero divisor
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 5 == 0) ? 32'h0 : $urandom;
            if (i == 7) begin f = 3'd4; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(f, a, b, model(f, a, b), exp_lat(f, a, b), 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
